// File: rtl/ddrio_pkg.sv
// Shared types for the DDR IO alignment sequencer: FSM state codes and the
// width of the phase timer that paces the reset wait, align pulses and settle
// windows.
package ddrio_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // Codes 6 and 7 are unused; the sequencer sends them back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN_O  = 3'd1,
    ST_SETTLE_O = 3'd2,
    ST_ALIGN_I  = 3'd3,
    ST_SETTLE_I = 3'd4,
    ST_READY    = 3'd5
  } state_e;

  // A phase lasting N cycles starts its down-counter at N-1 and exits when
  // the counter reads zero.
  function automatic cnt_t phase_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/ddrio_tog_sync.sv
// Brings the realign toggle from the sysclk domain into the edge-clock domain
// and turns every toggle into a one-cycle pulse.
module ddrio_tog_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tog_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Either polarity of toggle counts as one request.
  assign edge_o = sync2_q ^ prev_q;

endmodule

// File: rtl/ddrio_align_seq.sv
// Alignment sequencer for an x2 DDR IO pair. After reset it waits, pulses the
// output-side align, lets it settle, pulses the input-side align, lets that
// settle, then enables the IO clocks. A toggle on realign_req re-runs the
// align/settle sequence without going back through the reset wait.
//
//  state    | meaning
//  ---------+-----------------------------------------------------
//  IDLE     | post-reset wait, RST_WAIT cycles
//  ALIGN_O  | align_ol high, ALIGN_PULSE cycles
//  SETTLE_O | quiet time after output align, SETTLE_WAIT cycles
//  ALIGN_I  | align_il high, ALIGN_PULSE cycles
//  SETTLE_I | quiet time after input align, SETTLE_WAIT cycles
//  READY    | cken/ready high until a realign request is pending
//
// Parameter legal range is 1..255 for all three timers.
module ddrio_align_seq
  import ddrio_pkg::*;
#(
  parameter int RST_WAIT    = 16,
  parameter int ALIGN_PULSE = 2,
  parameter int SETTLE_WAIT = 8
) (
  input  logic       geclk_ol_buf_o,
  input  logic       align_rst_ol,
  input  logic       realign_req,
  output logic       align_ol,
  output logic       align_il,
  output logic       cken,
  output logic       ready,
  output logic       realign_ack,
  output logic [2:0] state_dbg
);

  localparam cnt_t RST_LD    = phase_load(RST_WAIT);
  localparam cnt_t PULSE_LD  = phase_load(ALIGN_PULSE);
  localparam cnt_t SETTLE_LD = phase_load(SETTLE_WAIT);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   pending_q, pending_d;
  logic   realign_q, realign_d;
  logic   ack_q, ack_d;
  logic   align_ol_q, align_il_q, cken_q, ready_q;
  logic   edge_det;

  ddrio_tog_sync u_tog_sync (
    .clk_i  (geclk_ol_buf_o),
    .rst_i  (align_rst_ol),
    .tog_i  (realign_req),
    .edge_o (edge_det)
  );

  // Next-state, phase timer and request bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | edge_det;
    realign_d = realign_q;
    ack_d     = ack_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q == '0) begin
          state_d = ST_ALIGN_O;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_ALIGN_O: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE_O;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_SETTLE_O: begin
        if (cnt_q == '0) begin
          state_d = ST_ALIGN_I;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_ALIGN_I: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE_I;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_SETTLE_I: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
          cnt_d   = '0;
          // Only a realignment is acknowledged; the cold-start pass is not.
          if (realign_q) begin
            ack_d = ~ack_q;
          end
          realign_d = 1'b0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_READY: begin
        if (pending_q) begin
          state_d   = ST_ALIGN_O;
          cnt_d     = PULSE_LD;
          // A toggle landing on this very edge is a fresh request.
          pending_d = edge_det;
          realign_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = RST_LD;
      end
    endcase
  end

  // State, timer and request flags.
  always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
    if (align_rst_ol) begin
      state_q   <= ST_IDLE;
      cnt_q     <= RST_LD;
      pending_q <= 1'b0;
      realign_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      realign_q <= realign_d;
      ack_q     <= ack_d;
    end
  end

  // Outputs decoded from the next state so they line up with state_q.
  always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
    if (align_rst_ol) begin
      align_ol_q <= 1'b0;
      align_il_q <= 1'b0;
      cken_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      align_ol_q <= (state_d == ST_ALIGN_O);
      align_il_q <= (state_d == ST_ALIGN_I);
      cken_q     <= (state_d == ST_READY);
      ready_q    <= (state_d == ST_READY);
    end
  end

  assign align_ol    = align_ol_q;
  assign align_il    = align_il_q;
  assign cken        = cken_q;
  assign ready       = ready_q;
  assign realign_ack = ack_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ddrio_align_seq.sv
// Directed bench for the DDR IO alignment sequencer. Cycle k is the interval
// after k rising edges since reset release; everything is sampled on the
// falling edge.
module tb_ddrio_align_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, req1;
  logic       ol0, il0, ck0, rdy0, ack0;
  logic [2:0] st0;
  logic       ol1, il1, ck1, rdy1, ack1;
  logic [2:0] st1;

  int errors = 0;
  int checks = 0;

  ddrio_align_seq u_def (
    .geclk_ol_buf_o (clk),
    .align_rst_ol   (rst),
    .realign_req    (req0),
    .align_ol       (ol0),
    .align_il       (il0),
    .cken           (ck0),
    .ready          (rdy0),
    .realign_ack    (ack0),
    .state_dbg      (st0)
  );

  ddrio_align_seq #(.RST_WAIT(1), .ALIGN_PULSE(1), .SETTLE_WAIT(1)) u_min (
    .geclk_ol_buf_o (clk),
    .align_rst_ol   (rst),
    .realign_req    (req1),
    .align_ol       (ol1),
    .align_il       (il1),
    .cken           (ck1),
    .ready          (rdy1),
    .realign_ack    (ack1),
    .state_dbg      (st1)
  );

  always @(negedge clk) begin
    checks++;
    if ((ol0 && il0) || (ol1 && il1)) begin
      errors++;
      $display("FAIL mutex t=%0t def=%b%b min=%b%b (required never both 1)",
               $time, ol0, il0, ol1, il1);
    end
  end

  // State j cycles after entering ALIGN_O with default timers.
  function automatic logic [2:0] seq_state(input int j);
    if (j < 2)       return 3'd1;
    else if (j < 10) return 3'd2;
    else if (j < 12) return 3'd3;
    else if (j < 20) return 3'd4;
    else             return 3'd5;
  endfunction

  function automatic logic [2:0] cold_state(input int k);
    if (k < 16) return 3'd0;
    return seq_state(k - 16);
  endfunction

  // {align_ol, align_il, cken, ready, realign_ack, state}
  function automatic logic [7:0] mk_exp(input logic [2:0] st, input logic ack);
    return {st == 3'd1, st == 3'd3, st == 3'd5, st == 3'd5, ack, st};
  endfunction

  function automatic logic [7:0] obs0();
    return {ol0, il0, ck0, rdy0, ack0, st0};
  endfunction

  function automatic logic [7:0] obs1();
    return {ol1, il1, ck1, rdy1, ack1, st1};
  endfunction

  // Hold reset two cycles, release on a falling edge: returns in cycle 0.
  task automatic apply_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    @(negedge clk);
    o = obs0();
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL reset_def got=%b exp=%b", o, 8'h00);
    end
    o = obs1();
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL reset_min got=%b exp=%b", o, 8'h00);
    end
  endtask

  task automatic test_cold_start();
    logic [7:0] o, e;
    apply_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      o = obs0();
      e = mk_exp(cold_state(k), 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cold k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  // Starts in READY (left there by test_cold_start).
  task automatic test_realign();
    logic [7:0] o, e;
    req0 = ~req0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      o = obs0();
      e = mk_exp((j <= 3) ? 3'd5 : seq_state(j - 4), j >= 24);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL realign j=%0d got=%b exp=%b", j, o, e);
      end
    end
  endtask

  task automatic test_multi_toggle();
    logic [7:0] o, e;
    apply_reset();
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) @(negedge clk);
      o = obs0();
      e = mk_exp((k <= 36) ? cold_state(k) : seq_state(k - 37), k >= 57);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL multi k=%0d got=%b exp=%b", k, o, e);
      end
      if (k == 19 || k == 21 || k == 23) req0 = ~req0;
    end
  endtask

  // Edge reaches pending on the same edge the FSM enters READY.
  task automatic test_edge_at_ready();
    logic [7:0] o, e;
    apply_reset();
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) @(negedge clk);
      o = obs0();
      e = mk_exp((k <= 36) ? cold_state(k) : seq_state(k - 37), k >= 57);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL edge_at_ready k=%0d got=%b exp=%b", k, o, e);
      end
      if (k == 33) req0 = ~req0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o, e;
    apply_reset();
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 20) req0 = ~req0;
    end
    o = obs0();
    e = mk_exp(3'd3, 1'b0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL pre_abort got=%b exp=%b", o, e);
    end
    rst = 1'b1;
    #1;
    o = obs0();
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL abort_now got=%b exp=%b", o, 8'h00);
    end
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 46; k++) begin
      if (k > 0) @(negedge clk);
      o = obs0();
      e = mk_exp(cold_state(k), 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rerun k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  task automatic test_min_params();
    logic [7:0] o, e;
    logic [2:0] s;
    apply_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      s = (k >= 5) ? 3'd5 : 3'(k);
      o = obs1();
      e = mk_exp(s, 1'b0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL min k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    test_reset();
    test_cold_start();
    test_realign();
    test_multi_toggle();
    test_edge_at_ready();
    test_reset_mid();
    test_min_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddrio_align_seq.md
DDRIO_ALIGN_SEQ -- requirements
Module: ddrio_align_seq

Interface
REQ-001 Parameter RST_WAIT, default 16: geclk_ol cycles held idle after reset release; legal range 1..255.
REQ-002 Parameter ALIGN_PULSE, default 2: high-time in cycles of each align pulse; legal range 1..255.
REQ-003 Parameter SETTLE_WAIT, default 8: cycles waited after each align pulse; legal range 1..255.
REQ-004 The block SHALL use geclk_ol_buf_o  input  1  as its clock: the output-path edge clock, also driven into the x2 DDR IO pair.
REQ-005 The block SHALL use align_rst_ol  input  1  as its reset: asynchronous, active-high.
REQ-006 realign_req  input  1  toggle from the sysclk domain; each edge requests one realignment.
REQ-007 align_ol  output  1  align pulse to the output update block.
REQ-008 align_il  output  1  align pulse to the input update block.
REQ-009 cken  output  1  clock enable to both IO cells.
REQ-010 ready  output  1  high while the IO pair is aligned and enabled.
REQ-011 realign_ack  output  1  toggles once per serviced realign request.
REQ-012 state_dbg  output  3  current FSM state encoding.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 The FSM SHALL have states IDLE(0), ALIGN_O(1), SETTLE_O(2), ALIGN_I(3), SETTLE_I(4), READY(5); codes 6-7 SHALL return to IDLE on the next edge.
REQ-015 IDLE: an 8-bit down-counter, loaded with RST_WAIT-1, decrements each cycle; at zero the FSM SHALL go to ALIGN_O.
REQ-016 ALIGN_O: align_ol high for exactly ALIGN_PULSE cycles, then SETTLE_O.
REQ-017 SETTLE_O: all pulses low for SETTLE_WAIT cycles, then ALIGN_I.
REQ-018 ALIGN_I: align_il high for exactly ALIGN_PULSE cycles, then SETTLE_I.
REQ-019 SETTLE_I: SETTLE_WAIT cycles, then READY.
REQ-020 cken and ready SHALL be high only in READY; both SHALL assert on the first cycle of READY.
REQ-021 align_ol and align_il SHALL never be high in the same cycle.
REQ-022 realign_req SHALL pass through a 2-flop synchronizer plus one edge-detect flop; each detected edge sets a pending flag.
REQ-023 READY with pending set: on the next edge the block SHALL clear pending, drop cken and ready, and enter ALIGN_O. IDLE is not revisited.
REQ-024 An edge detected while not in READY SHALL only set pending. Multiple edges before service SHALL collapse into one request.
REQ-025 An edge detected in the same cycle the FSM enters READY SHALL be serviced: READY lasts one cycle, then ALIGN_O.
REQ-026 realign_ack SHALL toggle on entry to READY at the end of a realignment, but not on entry at the end of the initial post-reset sequence.
REQ-027 Cold-start latency from reset release to ready = RST_WAIT + 2*ALIGN_PULSE + 2*SETTLE_WAIT cycles (default 36).

Reset
REQ-028 Asserting align_rst_ol SHALL immediately force:
- state IDLE, counter RST_WAIT-1
- align_ol, align_il, cken, ready low
- pending clear, realign_ack 0
- synchronizer and edge flops 0
REQ-029 Reset asserted mid-sequence or in READY SHALL abort any pending realignment; after release the full cold-start sequence SHALL rerun.

Structure
REQ-030 State encodings and the 8-bit counter width SHALL live in the shared package ddrio_pkg.
REQ-031 The toggle synchronizer and edge detector SHALL be the sub-module ddrio_tog_sync; the FSM and counter stay in this module.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Defaults, release reset at cycle 0 -> align_ol high in cycles 16-17, align_il high in cycles 26-27, cken/ready rise at cycle 36, realign_ack stays 0.
- In READY, toggle realign_req once -> cken falls about 4 cycles later, align_ol pulses 2 cycles, ready returns after 20 cycles, realign_ack = 1.
- Three realign_req toggles during SETTLE_O -> exactly one extra realignment after READY, realign_ack toggles once.
- Reset asserted during ALIGN_I -> all outputs 0 the same cycle, then the full 36-cycle sequence after release.
- RST_WAIT=1, ALIGN_PULSE=1, SETTLE_WAIT=1 -> ready at cycle 5.
- Assertion over all runs -> align_ol & align_il never both 1.
